mdu_mac: RTL and testbench
==========================

// Module: mdu_mac
// PURPOSE
//  Parametrised multi-cycle multiply/accumulate unit that owns the architectural HI/LO pair.
//  Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU with an iterative radix-2^RADIX_BITS multiplier.
//  Executes MTHI/MTLO as single-cycle writes.
//  Sits beside the EX stage; the pipeline stalls MFHI/MFLO and new MDU ops while o_busy=1.
// PARAMETERS
//  DATA_W     32  operand width; HI/LO are DATA_W each, accumulator is 2*DATA_W
//  RADIX_BITS 2   multiplier bits retired per CALC cycle; legal values 1,2,4,8
//                 DATA_W % RADIX_BITS must be 0, else $error at elaboration
// PORTS
//  i_clk     in   1       single clock, rising edge
//  i_rst_n   in   1       reset, synchronous, active-low
//  i_valid   in   1       op request
//  o_ready   out  1       unit can accept; = (state==IDLE) && i_rst_n
//  i_op      in   3       0 MULT,1 MULTU,2 MADD,3 MADDU,4 MSUB,5 MSUBU,6 MTHI,7 MTLO
//  i_rs      in   DATA_W  multiplicand / MTHI/MTLO source
//  i_rt      in   DATA_W  multiplier
//  i_flush   in   1       abort in-flight op (only when MDU_FLUSH_EN is defined)
//  o_busy    out  1       multi-cycle op in flight (state!=IDLE)
//  o_done    out  1       one-cycle pulse: HI/LO just updated by an accepted op
//  o_hi      out  DATA_W  architectural HI
//  o_lo      out  DATA_W  architectural LO
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): state=IDLE, HI=LO=0, o_done=0, o_busy=0, counter=0.
//   Reset mid-op discards the op: no o_done, HI/LO=0.
//  Accept: i_valid && o_ready sampled at an edge (cycle c0).
//   i_op, i_rs and i_rt are captured; later input changes are ignored.
//  MTHI/MTLO: HI (resp. LO) <= i_rs at the c0 edge; state stays IDLE; o_done=1 in c1.
//  Mul ops: IDLE -> CALC, cnt=0.
//   Signed ops (0,2,4) use operand magnitudes plus a result-sign bit.
//   Unsigned ops use the raw operand values.
//  CALC: each cycle adds mcand*digit(RADIX_BITS LSBs of multiplier) to the partial product,
//   shifts the multiplier right by RADIX_BITS and increments cnt.
//   When cnt==ITER-1 (ITER=DATA_W/RADIX_BITS) -> FIN.
//  FIN (one cycle): form the 2*DATA_W product, negated if the sign bit is set.
//   MULT/MULTU:  {HI,LO} <= P
//   MADD/MADDU:  {HI,LO} <= {HI,LO} + P
//   MSUB/MSUBU:  {HI,LO} <= {HI,LO} - P
//   All results wrap modulo 2^(2*DATA_W); no overflow flag. Then state -> IDLE, o_done <= 1.
//  Latency: o_done=1 and new HI/LO are visible in cycle c0+ITER+2 (18 at defaults).
//   o_ready=1 again in that same cycle; back-to-back accept is allowed there.
//  HI/LO hold their old values during CALC/FIN and change only at the FIN edge.
//  i_valid while busy: not accepted; the requester holds it. No queueing.
//  -MIN: MULT 0x80000000*0x80000000 -> {HI,LO}=0x40000000_00000000.
//   The magnitude path must be DATA_W+1 safe.
// CONFIGURATION
//  MDU_FLUSH_EN defined: i_flush exists.
//   i_flush=1 at any edge forces state=IDLE and cnt=0; HI/LO are not updated; o_done=0 next cycle.
//   In IDLE, a flush coinciding with i_valid discards that op, including MTHI/MTLO.
//   A flush coinciding with FIN cancels the write.
//  MDU_FLUSH_EN undefined: no i_flush port; every accepted op always completes.
// TESTING (defaults DATA_W=32, RADIX_BITS=2)
//  Reset, MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_done at c0+18 only.
//  MULT 0xFFFFFFFD(-3)*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  MTHI 0, MTLO 5, MADD -2*3 -> HI=LO=0xFFFFFFFF; then MSUBU 1*1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  Wrap: HI=LO=0xFFFFFFFF, MADDU 1*1 -> HI=LO=0; o_done single pulse.
//  Backpressure: i_valid held across a busy op -> o_ready=0 for cycles c1..c17, 2nd op accepted at c18, exactly two o_done.
//  Reset pulled low at c8 of MADD -> HI=LO=0, no o_done, o_ready=1 after release.
//   With MDU_FLUSH_EN, i_flush at c5 -> HI/LO unchanged, no o_done.

Source files
------------

// File: rtl/mdu_mac.sv
// Iterative radix-2^RADIX_BITS multiply/accumulate unit owning the HI/LO register pair.
// Optional abort input i_flush is present only when MDU_FLUSH_EN is defined.
module mdu_mac #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
`ifdef MDU_FLUSH_EN
    input  logic              i_flush,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int unsigned ITER  = DATA_W / RADIX_BITS;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned ACC_W = 2 * DATA_W;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4 || RADIX_BITS == 8) ||
        (DATA_W % RADIX_BITS) != 0) begin : g_bad_param
        $error("mdu_mac: illegal RADIX_BITS/DATA_W combination");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic [ACC_W-1:0]   r_mcand, w_mcand_nxt;
    logic [DATA_W-1:0]  r_mplier, w_mplier_nxt;
    logic               r_neg, w_neg_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [DATA_W-1:0]  r_hi, w_hi_nxt;
    logic [DATA_W-1:0]  r_lo, w_lo_nxt;
    logic               r_done, w_done_nxt;

    logic               w_flush;
    logic               w_accept;
    logic               w_is_signed;
    logic               w_rs_neg, w_rt_neg;
    logic [DATA_W-1:0]  w_rs_mag, w_rt_mag;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_prod;
    logic [ACC_W-1:0]   w_res;

`ifdef MDU_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign o_ready  = (r_state == StIdle) && i_rst_n;
    assign o_busy   = (r_state != StIdle);
    assign o_done   = r_done;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign w_accept = i_valid && o_ready;

    // Magnitudes are taken as unsigned DATA_W values so that -MIN maps to 2^(DATA_W-1).
    assign w_is_signed = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_MSUB);
    assign w_rs_neg    = w_is_signed && i_rs[DATA_W-1];
    assign w_rt_neg    = w_is_signed && i_rt[DATA_W-1];
    assign w_rs_mag    = w_rs_neg ? (~i_rs + DATA_W'(1)) : i_rs;
    assign w_rt_mag    = w_rt_neg ? (~i_rt + DATA_W'(1)) : i_rt;

    always_comb begin
        w_term = '0;
        for (int b = 0; b < int'(RADIX_BITS); b++) begin
            if (r_mplier[b]) w_term = w_term + (r_mcand << b);
        end
    end

    always_comb begin
        w_prod = r_neg ? (~r_acc + ACC_W'(1)) : r_acc;
        case (r_op)
            OP_MADD, OP_MADDU: w_res = {r_hi, r_lo} + w_prod;
            OP_MSUB, OP_MSUBU: w_res = {r_hi, r_lo} - w_prod;
            default:           w_res = w_prod;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_neg_nxt    = r_neg;
        w_acc_nxt    = r_acc;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (i_op == OP_MTHI) begin
                        w_hi_nxt   = i_rs;
                        w_done_nxt = 1'b1;
                    end else if (i_op == OP_MTLO) begin
                        w_lo_nxt   = i_rs;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = StCalc;
                        w_cnt_nxt    = '0;
                        w_op_nxt     = i_op;
                        w_mcand_nxt  = {{DATA_W{1'b0}}, w_rs_mag};
                        w_mplier_nxt = w_rt_mag;
                        w_neg_nxt    = w_rs_neg ^ w_rt_neg;
                        w_acc_nxt    = '0;
                    end
                end
            end
            StCalc: begin
                w_acc_nxt    = r_acc + w_term;
                w_mcand_nxt  = r_mcand << RADIX_BITS;
                w_mplier_nxt = r_mplier >> RADIX_BITS;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = StFin;
            end
            StFin: begin
                {w_hi_nxt, w_lo_nxt} = w_res;
                w_state_nxt          = StIdle;
                w_done_nxt           = 1'b1;
            end
            default: w_state_nxt = StIdle;
        endcase

        // Abort wins over everything, including an MTHI/MTLO or FIN write this cycle.
        if (w_flush) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_neg    <= w_neg_nxt;
            r_acc    <= w_acc_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_mdu_mac.sv
// Scoreboard bench for mdu_mac at DATA_W=32, RADIX_BITS=2; expected HI/LO come from a
// 64-bit behavioural model and are queued at issue time, popped when o_done fires.
module tb_mdu_mac;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors;
    int          checks;
    int          done_cnt;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_mac #(.DATA_W(32), .RADIX_BITS(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .o_ready (ready),
        .i_op    (op),
        .i_rs    (rs),
        .i_rt    (rt),
`ifdef MDU_FLUSH_EN
        .i_flush (flush),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Advance to the sample point of the next cycle (1 time unit after the edge).
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic        [63:0] p, hl;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        hl = {m_hi, m_lo};
        if (o == 3'd0 || o == 3'd2 || o == 3'd4) p = sa * sb;
        else                                     p = {32'd0, a} * {32'd0, b};
        case (o)
            3'd0, 3'd1: return p;
            3'd2, 3'd3: return hl + p;
            3'd4, 3'd5: return hl - p;
            3'd6:       return {a, m_lo};
            default:    return {m_hi, a};
        endcase
    endfunction

    // Drives one request for the accept cycle c0 and leaves the bench at the c1 sample point.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        valid = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        e = model(o, a, b);
        {m_hi, m_lo} = e;
        exp_q.push_back(e);
        step(1);
        valid = 1'b0;
        op    = 3'($urandom_range(0, 7));
        rs    = $urandom;
        rt    = $urandom;
    endtask

    // Returns the cycle index (c1 = 1) of the first o_done, or -1 when none within the bound.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        valid = 1'b1;
        op    = 3'd6;
        rs    = 32'hDEAD_BEEF;
        step(2);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo got=%h want=0", {hi, lo});
        end
        valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", ready); end
        step(1);
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_multu;
        int lat;
        logic [63:0] e;
        int d0;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL multu_busy got=%b/%b want=1/0", busy, ready);
        end
        step(8);
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("FAIL multu_hold got=%h want=0", {hi, lo});
        end
        d0 = done_cnt;
        wait_done(lat);
        lat = lat + 8;
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL multu_latency got=%0d want=18", lat); end
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e || e !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL multu_result got=%h want=%h", {hi, lo}, e);
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL multu_ready got=%b want=1", ready); end
        step(1);
        checks++;
        if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL multu_pulse got=%0d pulses want=1", done_cnt - d0);
        end
    endtask

    task automatic test_mult_signed;
        int lat;
        logic [63:0] e;
        logic [31:0] a[3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] b[3] = '{32'd7, 32'h8000_0000, 32'hF000_0001};
        logic [63:0] w[3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'd0};
        for (int i = 0; i < 3; i++) begin
            issue(3'd0, a[i], b[i]);
            wait_done(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== 18 || {hi, lo} !== e || (i < 2 && e !== w[i])) begin
                errors++;
                $display("FAIL mult_signed_%0d got=%h lat=%0d want=%h lat=18", i, {hi, lo}, lat, e);
            end
            step(1);
        end
    endtask

    task automatic test_madd_msub;
        int lat;
        logic [63:0] e;
        issue(3'd6, 32'd0, 32'd0);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1 || {hi, lo} !== e) begin
            errors++; $display("FAIL mthi got=%h lat=%0d want=%h lat=1", {hi, lo}, lat, e);
        end
        issue(3'd7, 32'd5, 32'd0);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1 || {hi, lo} !== 64'h0000_0000_0000_0005) begin
            errors++; $display("FAIL mtlo got=%h lat=%0d want=%h lat=1", {hi, lo}, lat, e);
        end
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 18 || {hi, lo} !== e || e !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL madd got=%h lat=%0d want=%h", {hi, lo}, lat, e);
        end
        step(1);
        issue(3'd5, 32'd1, 32'd1);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 18 || {hi, lo} !== e || e !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL msubu got=%h lat=%0d want=%h", {hi, lo}, lat, e);
        end
        step(1);
    endtask

    task automatic test_wrap;
        int lat;
        int d0;
        logic [63:0] e;
        issue(3'd6, 32'hFFFF_FFFF, 32'd0);
        void'(exp_q.pop_front());
        issue(3'd7, 32'hFFFF_FFFF, 32'd0);
        void'(exp_q.pop_front());
        step(1);
        d0 = done_cnt;
        issue(3'd3, 32'd1, 32'd1);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e || e !== 64'd0) begin
            errors++; $display("FAIL wrap_result got=%h want=%h", {hi, lo}, e);
        end
        step(3);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL wrap_pulse got=%0d pulses want=1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int d0;
        int bad;
        logic [63:0] e;
        logic [31:0] a2, b2;
        a2 = $urandom;
        b2 = $urandom;
        d0 = done_cnt;
        issue(3'd1, 32'h0001_0003, 32'hABCD_0007);
        valid = 1'b1;
        op    = 3'd4;
        rs    = a2;
        rt    = b2;
        bad = 0;
        for (int c = 1; c <= 17; c++) begin
            if (ready !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_ready_low got=%0d high cycles want=0", bad); end
        e = exp_q.pop_front();
        checks++;
        if (ready !== 1'b1 || done !== 1'b1 || {hi, lo} !== e) begin
            errors++; $display("FAIL b2b_first got=%h rdy=%b done=%b want=%h", {hi, lo}, ready, done, e);
        end
        issue(3'd4, a2, b2);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 18 || {hi, lo} !== e) begin
            errors++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=18", {hi, lo}, lat, e);
        end
        step(3);
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++; $display("FAIL b2b_pulses got=%0d want=2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_op;
        int d0;
        checks++;
        if ({hi, lo} === 64'd0) begin errors++; $display("FAIL midrst_setup got=0 want=nonzero"); end
        d0 = done_cnt;
        issue(3'd2, 32'h0000_1234, 32'h0000_5678);
        step(7);
        rst_n = 1'b0;
        step(1);
        void'(exp_q.pop_front());
        m_hi = '0;
        m_lo = '0;
        checks++;
        if ({hi, lo} !== 64'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_state got=%h busy=%b want=0 busy=0", {hi, lo}, busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", ready); end
        step(20);
        checks++;
        if (done_cnt !== d0 || {hi, lo} !== 64'd0) begin
            errors++; $display("FAIL midrst_nodone got=%0d pulses hilo=%h want=0", done_cnt - d0, {hi, lo});
        end
    endtask

`ifdef MDU_FLUSH_EN
    task automatic test_flush;
        int d0;
        logic [63:0] prev;
        issue(3'd7, 32'h0000_00AA, 32'd0);
        void'(exp_q.pop_front());
        step(1);
        prev = {hi, lo};
        d0 = done_cnt;
        issue(3'd1, 32'h0000_0FFF, 32'h0000_0FFF);
        void'(exp_q.pop_front());
        {m_hi, m_lo} = prev;
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle got=%b/%b want=0/1", busy, ready);
        end
        step(20);
        checks++;
        if (done_cnt !== d0 || {hi, lo} !== prev) begin
            errors++; $display("FAIL flush_calc got=%h pulses=%0d want=%h 0", {hi, lo}, done_cnt - d0, prev);
        end
        flush = 1'b1;
        issue(3'd6, 32'h5555_5555, 32'd0);
        void'(exp_q.pop_front());
        flush = 1'b0;
        {m_hi, m_lo} = prev;
        step(2);
        checks++;
        if (done_cnt !== d0 || {hi, lo} !== prev) begin
            errors++; $display("FAIL flush_mthi got=%h want=%h", {hi, lo}, prev);
        end
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        op       = '0;
        rs       = '0;
        rt       = '0;
        flush    = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        step(1);
        test_reset;
        test_multu;
        test_mult_signed;
        test_madd_msub;
        test_wrap;
        test_back_to_back;
        test_reset_mid_op;
`ifdef MDU_FLUSH_EN
        test_flush;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
